// File: rtl/snake_dir_cmd_gen.sv
// Turns five raw player buttons into a filtered snake command and issues it on the game
// tick: cmd_out is set up one cycle ahead of a single-cycle cmd_select strobe.
module snake_dir_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_pause,
    input  logic       tick,
    output logic [2:0] cmd_out,
    output logic       cmd_select,
    output logic [2:0] cur_dir,
    output logic [1:0] fsm_state
);

    localparam logic [2:0] CMD_NONE  = 3'b000;
    localparam logic [2:0] CMD_UP    = 3'b001;
    localparam logic [2:0] CMD_DOWN  = 3'b010;
    localparam logic [2:0] CMD_LEFT  = 3'b011;
    localparam logic [2:0] CMD_RIGHT = 3'b100;
    localparam logic [2:0] CMD_PAUSE = 3'b101;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 pause.
    logic [4:0]    raw_btn;
    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    deb_q, deb_d, deb_prev_q;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];
    logic [4:0]    press;

    logic [1:0] state_q, state_d;
    logic [2:0] cmd_q, cmd_d;
    logic [2:0] dir_q, dir_d;
    logic       pend_valid_q, pend_valid_d;
    logic [2:0] pend_cmd_q, pend_cmd_d;
    logic [2:0] press_cmd;
    logic       acc_valid;
    logic       issue;

    assign raw_btn = {btn_pause, btn_right, btn_left, btn_down, btn_up};

    // A level is accepted only after it has disagreed with the debounced value for
    // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    always_comb begin
        press_cmd = CMD_NONE;
        if (press[4])      press_cmd = CMD_PAUSE;
        else if (press[0]) press_cmd = CMD_UP;
        else if (press[1]) press_cmd = CMD_DOWN;
        else if (press[2]) press_cmd = CMD_LEFT;
        else if (press[3]) press_cmd = CMD_RIGHT;
    end

    function automatic logic is_reverse(input logic [2:0] a, input logic [2:0] b);
        return ((a == CMD_UP)   && (b == CMD_DOWN))  || ((a == CMD_DOWN)  && (b == CMD_UP)) ||
               ((a == CMD_LEFT) && (b == CMD_RIGHT)) || ((a == CMD_RIGHT) && (b == CMD_LEFT));
    endfunction

    always_comb begin
        acc_valid = 1'b0;
        if (press_cmd == CMD_PAUSE) begin
            acc_valid = 1'b1;
        end else if (press_cmd != CMD_NONE) begin
            acc_valid = (press_cmd != dir_q) && !is_reverse(press_cmd, dir_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        dir_d        = dir_q;
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        issue        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && pend_valid_q) begin
                    issue        = 1'b1;
                    cmd_d        = pend_cmd_q;
                    pend_valid_d = 1'b0;
                    state_d      = S_SETUP;
                    if (pend_cmd_q != CMD_PAUSE) dir_d = pend_cmd_q;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // A still-pending PAUSE is protected from later directions.
        if (acc_valid) begin
            if (!(pend_valid_q && !issue && (pend_cmd_q == CMD_PAUSE) &&
                  (press_cmd != CMD_PAUSE))) begin
                pend_valid_d = 1'b1;
                pend_cmd_d   = press_cmd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            state_q      <= S_IDLE;
            cmd_q        <= CMD_NONE;
            dir_q        <= CMD_RIGHT;
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= CMD_NONE;
        end else begin
            sync1_q      <= raw_btn;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_q;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            dir_q        <= dir_d;
            pend_valid_q <= pend_valid_d;
            pend_cmd_q   <= pend_cmd_d;
        end
    end

    assign cmd_out    = cmd_q;
    assign cmd_select = (state_q == S_STROBE);
    assign cur_dir    = dir_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_snake_dir_cmd_gen.sv
// Directed bench for snake_dir_cmd_gen: button presses, filtering, pending rules,
// issue handshake timing and asynchronous reset mid-strobe.
module tb_snake_dir_cmd_gen;

    logic       clk;
    logic       rst_n;
    logic [4:0] btns;  // 0 up, 1 down, 2 left, 3 right, 4 pause
    logic       tick;
    logic [2:0] cmd_out;
    logic       cmd_select;
    logic [2:0] cur_dir;
    logic [1:0] fsm_state;

    int n_pass  = 0;
    int n_total = 0;

    snake_dir_cmd_gen #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btns[0]),
        .btn_down   (btns[1]),
        .btn_left   (btns[2]),
        .btn_right  (btns[3]),
        .btn_pause  (btns[4]),
        .tick       (tick),
        .cmd_out    (cmd_out),
        .cmd_select (cmd_select),
        .cur_dir    (cur_dir),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance n clocks, ending 1 time unit after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [4:0] mask);
        btns = mask;
        cyc(10);
        btns = '0;
        cyc(10);
    endtask

    task automatic glitch(input logic [4:0] mask, input int len);
        btns = mask;
        cyc(len);
        btns = '0;
        cyc(12);
    endtask

    task automatic issue(input string tag, input logic [2:0] exp_cmd, input logic [2:0] exp_dir);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check({tag, "_cmd"}, 8'(cmd_out), 8'(exp_cmd));
        check({tag, "_dir"}, 8'(cur_dir), 8'(exp_dir));
        check({tag, "_setup_sel"}, 8'(cmd_select), 8'd0);
        cyc(1);
        check({tag, "_strobe_sel"}, 8'(cmd_select), 8'd1);
        check({tag, "_strobe_cmd"}, 8'(cmd_out), 8'(exp_cmd));
        cyc(1);
        check({tag, "_after_sel"}, 8'(cmd_select), 8'd0);
    endtask

    task automatic no_issue(input string tag, input logic [2:0] exp_cmd);
        int strobes;
        strobes = 0;
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        repeat (4) begin
            if (cmd_select) strobes++;
            cyc(1);
        end
        check({tag, "_strobes"}, 8'(strobes), 8'd0);
        check({tag, "_cmd"}, 8'(cmd_out), 8'(exp_cmd));
    endtask

    initial begin
        int strobes;
        rst_n = 1'b0;
        btns  = '0;
        tick  = 1'b0;
        #12;
        check("rst_cmd", 8'(cmd_out), 8'h0);
        check("rst_sel", 8'(cmd_select), 8'h0);
        check("rst_dir", 8'(cur_dir), 8'h4);
        check("rst_state", 8'(fsm_state), 8'h0);
        rst_n = 1'b1;
        cyc(2);

        // Idle with ticks, nothing pressed.
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick = (i % 3 == 0);
            cyc(1);
            if (cmd_select) strobes++;
        end
        tick = 1'b0;
        check("idle_strobes", 8'(strobes), 8'd0);
        check("idle_cmd", 8'(cmd_out), 8'h0);
        check("idle_dir", 8'(cur_dir), 8'h4);

        // LEFT is the reverse of RIGHT.
        press(5'b00100);
        no_issue("rev_left", 3'b000);

        press(5'b00001);
        issue("up", 3'b001, 3'b001);

        press(5'b00100);
        issue("left", 3'b011, 3'b011);

        // Short glitch on a legal direction.
        glitch(5'b00010, 2);
        no_issue("glitch", 3'b011);

        // Later direction overwrites the pending one; one issue only.
        press(5'b00010);
        press(5'b00001);
        issue("ovr_up", 3'b001, 3'b001);
        no_issue("ovr_once", 3'b001);

        // DOWN is reversed away, LEFT survives.
        press(5'b00010);
        press(5'b00100);
        issue("down_left", 3'b011, 3'b011);
        no_issue("down_left_once", 3'b011);

        // PAUSE beats RIGHT; a later UP cannot displace pending PAUSE.
        press(5'b11000);
        press(5'b00001);
        issue("pause", 3'b101, 3'b011);
        no_issue("pause_once", 3'b101);

        // Reset in the middle of the strobe.
        press(5'b00010);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("mid_setup_cmd", 8'(cmd_out), 8'h2);
        check("mid_setup_dir", 8'(cur_dir), 8'h2);
        cyc(1);
        check("mid_strobe_sel", 8'(cmd_select), 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel", 8'(cmd_select), 8'h0);
        check("arst_cmd", 8'(cmd_out), 8'h0);
        check("arst_dir", 8'(cur_dir), 8'h4);
        check("arst_state", 8'(fsm_state), 8'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        no_issue("post_rst", 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
